// File: rtl/btn_debounce.sv
// Button input conditioning: per-button invert, synchronise, debounce, press/release pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module btn_debounce #(
  parameter int                  NUM_BTN         = 7,
  parameter int                  DEBOUNCE_CYCLES = 250000,
  parameter int                  SYNC_STAGES     = 2,
  parameter logic [NUM_BTN-1:0]  INVERT_MASK     = 7'b0000001,
  parameter int                  REPEAT_DELAY    = 12500000,
  parameter int                  REPEAT_RATE     = 2500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync_r [SYNC_STAGES];
  logic [NUM_BTN-1:0] sync_s;
  logic [NUM_BTN-1:0] stable_r;
  logic [NUM_BTN-1:0] accept_s;
  logic [NUM_BTN-1:0] rep_fire_s;
  logic [CW-1:0]      cnt_r   [NUM_BTN];
  logic [CW-1:0]      cnt_nxt [NUM_BTN];
  logic [NUM_BTN-1:0] press_r;
  logic [NUM_BTN-1:0] release_r;

  // Synchroniser chain; active-low pins are inverted before the first flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {NUM_BTN{1'b0}};
      end
    end else begin
      sync_r[0] <= btn_raw ^ INVERT_MASK;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Per-button mismatch counter; any return to the stable value restarts it.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      accept_s[i] = (sync_s[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST);
      if (sync_s[i] == stable_r[i]) begin
        cnt_nxt[i] = {CW{1'b0}};
      end else if (accept_s[i]) begin
        cnt_nxt[i] = {CW{1'b0}};
      end else begin
        cnt_nxt[i] = cnt_r[i] + CW'(1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]      rep_cnt_r [NUM_BTN];
  logic [NUM_BTN-1:0] rep_first_r;

  // A repeat fires while held, never in the cycle a release is being accepted.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (stable_r[i] && !accept_s[i]) begin
        rep_fire_s[i] = (rep_cnt_r[i] == (rep_first_r[i] ? REP_FIRST : REP_NEXT));
      end else begin
        rep_fire_s[i] = 1'b0;
      end
    end
  end

  // Repeat interval counter, restarted on every acceptance and every repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        rep_cnt_r[i] <= {RW{1'b0}};
      end
      rep_first_r <= {NUM_BTN{1'b1}};
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!stable_r[i] || accept_s[i]) begin
          rep_cnt_r[i]   <= {RW{1'b0}};
          rep_first_r[i] <= 1'b1;
        end else if (rep_fire_s[i]) begin
          rep_cnt_r[i]   <= {RW{1'b0}};
          rep_first_r[i] <= 1'b0;
        end else begin
          rep_cnt_r[i]   <= rep_cnt_r[i] + RW'(1);
          rep_first_r[i] <= rep_first_r[i];
        end
      end
    end
  end
`else
  assign rep_fire_s = {NUM_BTN{1'b0}};
`endif

  // Debounce state and pulse registers; pulses coincide with the level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
      stable_r  <= {NUM_BTN{1'b0}};
      press_r   <= {NUM_BTN{1'b0}};
      release_r <= {NUM_BTN{1'b0}};
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_r[i] <= cnt_nxt[i];
      end
      stable_r  <= stable_r ^ accept_s;
      press_r   <= (accept_s & sync_s) | rep_fire_s;
      release_r <= accept_s & ~sync_s;
    end
  end

  assign btn_level   = stable_r;
  assign btn_press   = press_r;
  assign btn_release = release_r;

endmodule
